// File: rtl/moving_sum_inverse_pkg.sv
// Shared types and defaults for the moving-sum decoder (moving_sum_inverse).
package moving_sum_inverse_types;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);

    typedef logic signed [DEFAULT_WIDTH-1:0] sample_t;
    typedef sample_t                         hist_t [DEFAULT_DEPTH];
    typedef logic [DEFAULT_PTR_W-1:0]        ptr_t;

    // Pointer width for a given window length; never collapses to zero bits.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/moving_sum_inverse_hist.sv
// Ring buffer of recovered samples: one read and one write at the same slot,
// synchronous zeroing on reset or clear, write pointer kept internally.
module moving_sum_inverse_hist
    import moving_sum_inverse_types::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PW    = ptr_bits(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_data,
    output logic signed [WIDTH-1:0] rd_data,
    output logic        [PW-1:0]    ptr
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    // The slot about to be overwritten holds the sample from DEPTH accepts ago.
    assign rd_data = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
        end else if (wr_en) begin
            mem[ptr] <= wr_data;
            ptr      <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/moving_sum_inverse.sv
// Moving-sum decoder: x[n] = y[n] - y[n-1] + x[n-DEPTH], one-cycle latency.
// Optional MOVING_SUM_INVERSE_STATS_EN adds sample_count and primed outputs.
module moving_sum_inverse
    import moving_sum_inverse_types::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PW    = ptr_bits(DEPTH)
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_sum,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_sample
`ifdef MOVING_SUM_INVERSE_STATS_EN
    ,
    output logic [15:0]             sample_count,
    output logic                    primed
`endif
);

    logic signed [WIDTH-1:0] prev_sum;
    logic signed [WIDTH-1:0] hist_rd;
    logic signed [WIDTH-1:0] x;
    logic        [PW-1:0]    hist_ptr;
    logic                    accept;

    assign accept = in_valid && !clear && !system1000_rst;

    // Modulo-2^WIDTH arithmetic; wrap is intentional and matches the encoder.
    assign x = in_sum - prev_sum + hist_rd;

    moving_sum_inverse_hist #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk     (system1000),
        .rst     (system1000_rst),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (x),
        .rd_data (hist_rd),
        .ptr     (hist_ptr)
    );

    always_ff @(posedge system1000) begin
        if (system1000_rst || clear) begin
            prev_sum   <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_sample <= x;
                prev_sum   <= in_sum;
            end
        end
    end

`ifdef MOVING_SUM_INVERSE_STATS_EN
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            sample_count <= '0;
        end else if (accept && sample_count != 16'hFFFF) begin
            sample_count <= sample_count + 16'd1;
        end
    end

    // The DEPTH-th accept since restart is the one writing the last slot.
    always_ff @(posedge system1000) begin
        if (system1000_rst || clear) begin
            primed <= 1'b0;
        end else if (accept && hist_ptr == PW'(DEPTH - 1)) begin
            primed <= 1'b1;
        end
    end
`else
    wire unused_ptr = ^hist_ptr;
`endif

endmodule

// File: tb/tb_moving_sum_inverse.sv
// Directed bench for moving_sum_inverse, with a reference moving-sum encoder.
module tb_moving_sum_inverse;

    logic              system1000     = 1'b0;
    logic              system1000_rst = 1'b1;
    logic              clear          = 1'b0;
    logic              in_valid       = 1'b0;
    logic signed [7:0] in_sum         = '0;
    logic              out_valid;
    logic signed [7:0] out_sample;
`ifdef MOVING_SUM_INVERSE_STATS_EN
    logic [15:0]       sample_count;
    logic              primed;
`endif

    int errors  = 0;
    int checks  = 0;
    int acc_cnt = 0;

    logic signed [7:0] win [16];
    int                wp;
    logic signed [7:0] ysum;
    logic signed [7:0] y, xr, last;
    logic              v;

    moving_sum_inverse dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_sum         (in_sum),
        .out_valid      (out_valid),
        .out_sample     (out_sample)
`ifdef MOVING_SUM_INVERSE_STATS_EN
        ,
        .sample_count   (sample_count),
        .primed         (primed)
`endif
    );

    always #5 system1000 = ~system1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enc_reset();
        ysum = '0;
        wp   = 0;
        for (int i = 0; i < 16; i++) win[i] = '0;
    endtask

    task automatic enc(input logic signed [7:0] xin, output logic signed [7:0] yo);
        ysum    = ysum + xin - win[wp];
        win[wp] = xin;
        wp      = (wp + 1) % 16;
        yo      = ysum;
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic vi, input logic signed [7:0] s, input logic c, input logic r);
        in_valid       = vi;
        in_sum         = s;
        clear          = c;
        system1000_rst = r;
        @(posedge system1000);
        #1;
        if (r) acc_cnt = 0;
        else if (vi && !c && acc_cnt < 65535) acc_cnt++;
        in_valid       = 1'b0;
        clear          = 1'b0;
        system1000_rst = 1'b0;
    endtask

    task automatic feed(input logic signed [7:0] xin, input string tag);
        logic signed [7:0] yy;
        enc(xin, yy);
        drive(1'b1, yy, 1'b0, 1'b0);
        chk({tag, "_v"}, out_valid, 1);
        chk(tag, out_sample, xin);
    endtask

    initial begin
        enc_reset();
        last = '0;

        // Reset state
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        chk("rst_v", out_valid, 0);
        chk("rst_s", out_sample, 0);
`ifdef MOVING_SUM_INVERSE_STATS_EN
        chk("rst_cnt", sample_count, 0);
        chk("rst_primed", primed, 0);
`endif

        // Impulse: y=5 x16 then y=0 x20 -> 5 then zeros
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'sd5, 1'b0, 1'b0);
            chk("imp_v", out_valid, 1);
            chk("imp_a", out_sample, (i == 0) ? 5 : 0);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'sd0, 1'b0, 1'b0);
            chk("imp_b", out_sample, 0);
        end

        // Constant 127 across pointer wrap
        drive(1'b0, 8'sd0, 1'b1, 1'b0);
        chk("clr_v", out_valid, 0);
        enc_reset();
        for (int i = 0; i < 40; i++) feed(8'sd127, "wrap");

        // Random samples with valid gaps
        drive(1'b0, 8'sd0, 1'b1, 1'b0);
        enc_reset();
        last = '0;
        for (int i = 0; i < 60; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                xr = 8'($urandom);
                enc(xr, y);
                drive(1'b1, y, 1'b0, 1'b0);
                chk("gap_v", out_valid, 1);
                chk("gap_s", out_sample, xr);
                last = xr;
            end else begin
                drive(1'b0, 8'($urandom), 1'b0, 1'b0);
                chk("gap_idle_v", out_valid, 0);
                chk("gap_hold", out_sample, last);
            end
        end

        // Clear mid-stream with in_valid on the same cycle
        drive(1'b0, 8'sd0, 1'b1, 1'b0);
        enc_reset();
        for (int i = 0; i < 10; i++) feed(8'($urandom), "pre_clr");
        drive(1'b1, 8'sd77, 1'b1, 1'b0);
        chk("cm_v", out_valid, 0);
        chk("cm_s", out_sample, 0);
`ifdef MOVING_SUM_INVERSE_STATS_EN
        chk("cm_primed", primed, 0);
        chk("cm_cnt", sample_count, acc_cnt);
`endif
        enc_reset();
        for (int i = 0; i < 20; i++) feed(8'($urandom), "post_clr");

        // Reset overrides clear and in_valid
        drive(1'b1, 8'sd9, 1'b1, 1'b1);
        chk("rp_v", out_valid, 0);
        chk("rp_s", out_sample, 0);
`ifdef MOVING_SUM_INVERSE_STATS_EN
        chk("rp_cnt", sample_count, 0);
`endif
        drive(1'b1, -8'sd3, 1'b0, 1'b0);
        chk("rp_first_v", out_valid, 1);
        chk("rp_first", out_sample, -3);

`ifdef MOVING_SUM_INVERSE_STATS_EN
        // Priming boundary and counter saturation
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) drive(1'b1, 8'sd0, 1'b0, 1'b0);
        chk("st_primed15", primed, 0);
        chk("st_cnt15", sample_count, 15);
        drive(1'b1, 8'sd0, 1'b0, 1'b0);
        chk("st_primed16", primed, 1);
        chk("st_cnt16", sample_count, 16);
        for (int i = 0; i < 70000; i++) drive(1'b1, 8'sd0, 1'b0, 1'b0);
        chk("st_sat", sample_count, 16'hFFFF);
        chk("st_sat_model", sample_count, acc_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
